// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the fetch stage and its PC unit.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DROP
  } lc3b_fetch_state;

  localparam lc3b_word LC3B_RESET_PC = 16'h0000;

endpackage

// File: rtl/pc_unit.sv
// Program counter register with +2 incrementer and redirect mux.
module pc_unit
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     load,
  input  logic     redirect,
  input  lc3b_word target,
  output lc3b_word pc,
  output lc3b_word pc_plus2
);

  assign pc_plus2 = pc + 16'd2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= LC3B_RESET_PC;
    end else if (redirect) begin
      // Instructions are halfword aligned; bit 0 of the target is ignored.
      pc <= {target[15:1], 1'b0};
    end else if (load) begin
      pc <= pc_plus2;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LC-3b instruction fetch: PC, imem handshake, one-entry skid and IF/ID slot.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/bubble counters.
module fetch_stage
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic [15:0] imem_address,
  output logic        imem_read,
  input  logic [15:0] imem_rdata,
  input  logic        imem_resp,
  output logic        if_valid,
  output logic [15:0] if_instruction,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_bubbles
`endif
);

  lc3b_fetch_state state_q, state_d;
  lc3b_word        pc, pc_plus2;
  lc3b_word        drop_addr_q, drop_addr_d;
  lc3b_word        skid_instr_q, skid_pc_q, skid_pc2_q;
  logic            skid_valid_q;
  logic            pc_load, load_word, load_skid, load_bubble, skid_fill;

  pc_unit u_pc_unit (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (pc_load),
    .redirect (br_taken),
    .target   (br_target),
    .pc       (pc),
    .pc_plus2 (pc_plus2)
  );

  always_comb begin
    state_d     = state_q;
    drop_addr_d = drop_addr_q;
    pc_load     = 1'b0;
    load_word   = 1'b0;
    load_skid   = 1'b0;
    load_bubble = 1'b0;
    skid_fill   = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (br_taken) begin
          // An outstanding read cannot be withdrawn; finish it in DROP.
          if (!imem_resp) begin
            state_d     = DROP;
            drop_addr_d = pc;
          end
        end else if (imem_resp) begin
          pc_load = 1'b1;
          if (stall) begin
            skid_fill = 1'b1;
            state_d   = HOLD;
          end else begin
            load_word = 1'b1;
          end
        end else if (!stall) begin
          load_bubble = 1'b1;
        end
      end
      HOLD: begin
        if (br_taken) begin
          state_d = FETCH;
        end else if (!stall) begin
          load_skid = 1'b1;
          state_d   = FETCH;
        end
      end
      DROP: begin
        if (imem_resp) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      drop_addr_q  <= LC3B_RESET_PC;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_pc2_q   <= '0;
    end else begin
      state_q     <= state_d;
      drop_addr_q <= drop_addr_d;
      if (skid_fill) begin
        skid_valid_q <= 1'b1;
        skid_instr_q <= imem_rdata;
        skid_pc_q    <= pc;
        skid_pc2_q   <= pc_plus2;
      end else if (br_taken || load_skid) begin
        skid_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_valid       <= 1'b0;
      if_instruction <= '0;
      if_pc          <= '0;
      if_pc_plus2    <= '0;
    end else if (br_taken) begin
      if_valid <= 1'b0;
    end else if (load_word) begin
      if_valid       <= 1'b1;
      if_instruction <= imem_rdata;
      if_pc          <= pc;
      if_pc_plus2    <= pc_plus2;
    end else if (load_skid) begin
      if_valid       <= 1'b1;
      if_instruction <= skid_instr_q;
      if_pc          <= skid_pc_q;
      if_pc_plus2    <= skid_pc2_q;
    end else if (load_bubble) begin
      if_valid <= 1'b0;
    end
  end

  assign imem_read    = (state_q == FETCH) || (state_q == DROP);
  assign imem_address = (state_q == DROP) ? drop_addr_q : pc;

`ifdef FETCH_PERF_CNT_EN
  logic fetched_evt, bubble_evt;

  assign fetched_evt = !br_taken && (load_word || load_skid);
  assign bubble_evt  = !stall && (br_taken || load_bubble);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (fetched_evt && perf_fetched != 16'hFFFF) perf_fetched <= perf_fetched + 16'd1;
      if (bubble_evt && perf_bubbles != 16'hFFFF) perf_bubbles <= perf_bubbles + 16'd1;
    end
  end
`endif

  logic unused_skid_valid;
  assign unused_skid_valid = skid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, reset corner, random vs model.
module tb_fetch_stage;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = '0;
  logic [15:0] imem_rdata = '0;
  logic        imem_resp = 1'b0;
  logic [15:0] imem_address;
  logic        imem_read;
  logic        if_valid;
  logic [15:0] if_instruction, if_pc, if_pc_plus2;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched, perf_bubbles;
`endif

  fetch_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .imem_address   (imem_address),
    .imem_read      (imem_read),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_pc_plus2    (if_pc_plus2)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed vectors: expected outputs seen this cycle, then inputs applied for the next edge.
  typedef struct {
    logic        st;
    logic        br;
    logic [15:0] tgt;
    logic        rsp;
    logic [15:0] rd;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_v;
    logic [15:0] e_pc;
    logic [15:0] e_ins;
  } vec_t;

  vec_t tbl[16];

  // Reference model: pipeline described as "waiting to start", "discarding", skid queue.
  typedef struct { logic [15:0] ins; logic [15:0] pc; } held_t;
  logic [15:0] m_pc, m_drop_addr, m_ins, m_ipc;
  logic        m_idle, m_drop, m_v;
  held_t       m_skid[$];
  int          m_fetched, m_bubbles;

  function automatic void model_reset();
    m_pc = LC3B_RESET_PC; m_idle = 1'b1; m_drop = 1'b0; m_drop_addr = '0;
    m_v = 1'b0; m_ins = '0; m_ipc = '0; m_skid.delete();
    m_fetched = 0; m_bubbles = 0;
  endfunction

  function automatic logic m_read();
    return !m_idle && (m_skid.size() == 0);
  endfunction

  function automatic logic [15:0] m_addr();
    return m_drop ? m_drop_addr : m_pc;
  endfunction

  function automatic void model_step(input logic st, input logic br, input logic [15:0] tgt,
                                     input logic rsp, input logic [15:0] rd);
    logic [15:0] t;
    t = tgt & 16'hFFFE;
    if (br) begin
      m_v = 1'b0;
      if (!st) m_bubbles++;
    end
    if (m_idle) begin
      if (br) m_pc = t;
      m_idle = 1'b0;
    end else if (m_skid.size() != 0) begin
      if (br) begin
        m_pc = t;
        m_skid.delete();
      end else if (!st) begin
        m_ins = m_skid[0].ins; m_ipc = m_skid[0].pc; m_v = 1'b1; m_fetched++;
        m_skid.delete();
      end
    end else if (m_drop) begin
      if (br) m_pc = t;
      if (rsp) m_drop = 1'b0;
    end else begin
      if (br) begin
        if (!rsp) begin
          m_drop = 1'b1;
          m_drop_addr = m_pc;
        end
        m_pc = t;
      end else if (rsp) begin
        if (st) m_skid.push_back('{ins: rd, pc: m_pc});
        else begin
          m_ins = rd; m_ipc = m_pc; m_v = 1'b1; m_fetched++;
        end
        m_pc = 16'(m_pc + 16'd2);
      end else if (!st) begin
        m_v = 1'b0;
        m_bubbles++;
      end
    end
  endfunction

  task automatic check_slot(input string tag, input logic e_v, input logic [15:0] e_pc,
                            input logic [15:0] e_ins);
    chk({tag, "_valid"}, {15'd0, if_valid}, {15'd0, e_v});
    if (e_v) begin
      chk({tag, "_pc"}, if_pc, e_pc);
      chk({tag, "_ins"}, if_instruction, e_ins);
      chk({tag, "_pc2"}, if_pc_plus2, 16'(e_pc + 16'd2));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stall = 1'b0; br_taken = 1'b0; imem_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic        r_st, r_br, r_rsp, req_act;
  logic [15:0] r_tgt, r_rd;
  int          lat, age;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1, 16'h0004, 1'b1, 16'h0002, 16'h0002};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h0002, 16'h0002};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h0002, 16'h0002};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h0002, 16'h0002};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h0006, 1'b1, 16'h0004, 16'h1234};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 16'h0006, 16'h0006};
    tbl[9]  = '{1'b0, 1'b1, 16'h3001, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b0, 16'h0000, 16'h0000};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b0, 16'h0000, 16'h0000};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b1, 16'h0008, 1'b0, 16'h0000, 16'h0000};
    tbl[12] = '{1'b0, 1'b1, 16'hFFFE, 1'b1, 16'hAAAA, 1'b1, 16'h3000, 1'b0, 16'h0000, 16'h0000};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'h0000};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'hFFFE, 16'h5555};
    tbl[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};

    #1;
    chk("rst_read", {15'd0, imem_read}, 16'h0000);
    chk("rst_valid", {15'd0, if_valid}, 16'h0000);
    chk("rst_ins", if_instruction, 16'h0000);
    chk("rst_pc", if_pc, 16'h0000);
    chk("rst_pc2", if_pc_plus2, 16'h0000);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("v%0d_read", i), {15'd0, imem_read}, {15'd0, tbl[i].e_rd});
      chk($sformatf("v%0d_addr", i), imem_address, tbl[i].e_addr);
      check_slot($sformatf("v%0d", i), tbl[i].e_v, tbl[i].e_pc, tbl[i].e_ins);
      stall = tbl[i].st; br_taken = tbl[i].br; br_target = tbl[i].tgt;
      imem_resp = tbl[i].rsp; imem_rdata = tbl[i].rd;
      @(posedge clk);
      @(negedge clk);
    end
    stall = 1'b0; br_taken = 1'b0; imem_resp = 1'b0;

    // Reset asserted while the read at 0000 is outstanding and the slot still holds FFFE/5555.
    reset_n = 1'b0;
    #1;
    chk("midrst_read", {15'd0, imem_read}, 16'h0000);
    chk("midrst_addr", imem_address, 16'h0000);
    chk("midrst_valid", {15'd0, if_valid}, 16'h0000);
    chk("midrst_pc", if_pc, 16'h0000);
    chk("midrst_ins", if_instruction, 16'h0000);
    chk("midrst_pc2", if_pc_plus2, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("idle_read", {15'd0, imem_read}, 16'h0000);
    imem_resp = 1'b1; imem_rdata = 16'hDEAD;  // stray response while idle
    @(posedge clk);
    @(negedge clk);
    imem_resp = 1'b0;
    chk("restart_read", {15'd0, imem_read}, 16'h0001);
    chk("restart_addr", imem_address, 16'h0000);
    chk("restart_valid", {15'd0, if_valid}, 16'h0000);
    imem_resp = 1'b1; imem_rdata = 16'h7777;
    @(posedge clk);
    @(negedge clk);
    imem_resp = 1'b0;
    check_slot("restart_first", 1'b1, 16'h0000, 16'h7777);
    chk("restart_next", imem_address, 16'h0002);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    req_act = 1'b0; lat = 0; age = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_read", {15'd0, imem_read}, {15'd0, m_read()});
      if (m_read()) chk("rnd_addr", imem_address, m_addr());
      check_slot("rnd", m_v, m_ipc, m_ins);
      r_st  = ($urandom_range(0, 3) == 0);
      r_br  = ($urandom_range(0, 11) == 0);
      r_tgt = 16'($urandom);
      if ($urandom_range(0, 20) == 0) r_tgt = 16'hFFFE;
      r_rd  = 16'($urandom);
      r_rsp = 1'b0;
      if (m_read()) begin
        if (!req_act) begin
          req_act = 1'b1;
          lat = $urandom_range(0, 3);
          age = 0;
        end
        r_rsp = (age == lat);
      end
      stall = r_st; br_taken = r_br; br_target = r_tgt; imem_resp = r_rsp; imem_rdata = r_rd;
      @(posedge clk);
      model_step(r_st, r_br, r_tgt, r_rsp, r_rd);
      if (r_rsp) req_act = 1'b0;
      else if (req_act) age++;
      @(negedge clk);
    end
    stall = 1'b0; br_taken = 1'b0; imem_resp = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 16'(m_fetched));
    chk("perf_bubbles", perf_bubbles, 16'(m_bubbles));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the LC-3b pipeline, directly upstream of decode. It owns the PC and drives the instruction-memory read handshake. Fetched instructions land in a registered IF/ID output slot (instruction, PC, PC+2, valid) that decode consumes. It honours downstream stall and branch redirect, and absorbs one early memory response in a skid register.

## Interface
- No parameters; widths come from `lc3b_types`.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `stall` in 1: decode cannot accept; output slot must hold.
- `br_taken` in 1: one-cycle redirect pulse.
- `br_target` in 16 (`lc3b_word`): redirect PC, sampled when `br_taken`=1.
- `imem_address` out 16: read address, equal to `pc` or the dropped address.
- `imem_read` out 1: read request, registered.
- `imem_rdata` in 16: instruction word, valid when `imem_resp`=1.
- `imem_resp` in 1: one-cycle completion. Zero-wait is legal (same cycle as the request).
- `if_valid` out 1: output slot holds a real instruction.
- `if_instruction` out 16: instruction to decode.
- `if_pc` out 16: address of `if_instruction`.
- `if_pc_plus2` out 16: `if_pc`+2, mod 2^16.

## Operation
- Reset values:
  - State is IDLE, `pc`=`LC3B_RESET_PC` (16'h0000), `imem_read`=0, `if_valid`=0.
  - `if_instruction`, `if_pc` and `if_pc_plus2` are 0.
  - The skid register is empty.
- States:
  - IDLE: `imem_read`=0. Unconditionally moves to FETCH on the next edge.
  - FETCH: `imem_read`=1, `imem_address`=`pc`.
    - On `imem_resp` with `stall`=0: the word loads into the output slot (`if_valid`=1), `pc`<=`pc`+2, and the state stays FETCH.
    - On `imem_resp` with `stall`=1: the word and its PC go into the skid register, `pc`<=`pc`+2, and the state moves to HOLD.
    - With no resp and `stall`=0: the output slot loads a bubble (`if_valid`=0).
  - HOLD: `imem_read`=0. When `stall`=0, skid moves to the output slot, skid empties, and the state moves to FETCH.
  - DROP: `imem_read`=1 with the address latched at redirect. On `imem_resp` the data is discarded and the state moves to FETCH at the redirected `pc`.
- Memory rule: once `imem_read` rises, address and read stay constant until `imem_resp`. Redirect never withdraws an outstanding request.
- Stall rule: when `stall`=1, all output-slot fields hold their values exactly.
- Redirect (`br_taken`=1) has priority over `stall` and resp:
  - `pc`<=`br_target`, `if_valid`<=0, skid cleared.
  - From FETCH without resp in the same cycle: go to DROP.
  - From FETCH with resp in the same cycle: discard the word, stay FETCH.
  - From HOLD or IDLE: go to FETCH.
  - In DROP: update `pc`, stay DROP.
- PC arithmetic: 16-bit wrap. 16'hFFFE+2 = 16'h0000. Bit 0 of `br_target` is forced to 0.
- Reset mid-transaction: everything returns to reset values immediately. A later stray `imem_resp` in IDLE is ignored.

## Timing
- Fetch latency: `imem_resp` at edge N makes `if_valid`=1 visible after edge N+1 (registered slot).
- Throughput: one instruction per cycle with zero-wait memory and no stall.
- Redirect: `br_taken` at cycle N gives `if_valid`=0 in N+1. The first target instruction appears one cycle after its resp.
- Stall release from HOLD: the skid word is visible the cycle after `stall` falls. Fetch restarts in that same cycle.
- There is no combinational path from any input to `imem_read`, `if_*`, or `imem_address`.

## Configuration
- Macro: `FETCH_PERF_CNT_EN`.
- Defined: adds outputs `perf_fetched` (16) and `perf_bubbles` (16).
  - `perf_fetched` counts cycles where the output slot loads a valid instruction.
  - `perf_bubbles` counts cycles where `stall`=0 and the slot loads a bubble.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- `lc3b_types` additions:
  - `lc3b_fetch_state` enum {IDLE, FETCH, HOLD, DROP}.
  - `LC3B_RESET_PC` = 16'h0000.
  - `lc3b_word` is reused for all 16-bit fields.
- Sub-module `pc_unit`: PC register, +2 adder, target mux. Load and redirect inputs; `pc` and `pc_plus2` outputs.
- The FSM, skid register and output slot stay in `fetch_stage`.

## Test plan
- Reset, then zero-wait memory returning word=address for 4 cycles → `if_pc` sequence 0000, 0002, 0004, 0006 on consecutive cycles, `if_instruction` matching.
- Resp with `stall`=1 for 3 cycles, word 16'h1234 at 0004 → HOLD with `imem_read`=0. Output frozen. 1234/0004 appears one cycle after `stall` falls.
- `br_taken`, target 16'h3001, while a 3-cycle-latency read at 0008 is outstanding:
  - `imem_read` stays high at 0008 until resp, and that word never becomes valid.
  - Next request is at 3000.
- `br_taken` in the same cycle as resp → word discarded, `if_valid`=0 next cycle, next address = target.
- Start at `br_target`=FFFE → `if_pc_plus2`=0000, next fetch address 0000.
- With `FETCH_PERF_CNT_EN`: 10 valid fetches and 3 bubbles → `perf_fetched`=10, `perf_bubbles`=3.
- `reset_n` low mid-read → outputs zero immediately, IDLE then FETCH at 0000.
